// File: rtl/cl_mask_pkg.sv
// cl_mask_pkg
// Shared helpers for the sparse-operand mask filter.
//   countWidth  : width of a saturating block-element counter, clog2(T)+1
//   idxWidth    : width of a window position, clog2(W)
//   popWidth    : width of a window popcount, clog2(W)+1
//   satPopcount : number of ones in a vector, saturated at a limit
package cl_mask_pkg;

    localparam int MAX_W = 256;

    function automatic int countWidth(input int transferSize);
        return $clog2(transferSize) + 1;
    endfunction

    function automatic int idxWidth(input int windowSize);
        return $clog2(windowSize);
    endfunction

    function automatic int popWidth(input int windowSize);
        return $clog2(windowSize) + 1;
    endfunction

    function automatic int satPopcount(input logic [MAX_W-1:0] bits, input int limit);
        int total;
        total = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (bits[i] && (total < limit)) begin
                total = total + 1;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/cl_mask_accumulator.sv
// cl_mask_accumulator
// Combinational saturating exclusive-prefix counter. For every window
// position i, accIndex[i] = min(popcount(effMask[i-1:0]), TRANSFER_SIZE).
// Ports:
//   effMask  in   effective mask, bits 0..W-2 (the top bit never feeds an
//                 exclusive prefix, so it is not brought in)
//   accIndex out  per-position saturated prefix count
module cl_mask_accumulator
    import cl_mask_pkg::*;
#(
    parameter int COMPRESSION_WINDOW_SIZE = 8,
    parameter int TRANSFER_SIZE = 2,
    localparam int COUNT_W = countWidth(TRANSFER_SIZE)
)(
    input  logic [COMPRESSION_WINDOW_SIZE-2:0]              effMask,
    output logic [COMPRESSION_WINDOW_SIZE-1:0][COUNT_W-1:0] accIndex
);

    localparam logic [COUNT_W-1:0] SAT = COUNT_W'(TRANSFER_SIZE);

    // Ripple chain; once the count reaches SAT it sticks, so the adder never
    // needs more than COUNT_W bits.
    always_comb begin
        accIndex = '0;
        for (int i = 1; i < COMPRESSION_WINDOW_SIZE; i++) begin
            if (accIndex[i-1] == SAT) begin
                accIndex[i] = SAT;
            end else begin
                accIndex[i] = accIndex[i-1] + COUNT_W'(effMask[i-1]);
            end
        end
    end

endmodule

// File: rtl/cl_mask_filter.sv
// cl_mask_filter
// Tracks the compression-window index of one compressed operand stream and,
// per transfer block, emits a dense select mask of the block elements that
// land on mutually non-zero positions.
// Optional feature macro: CL_MASK_FILTER_POPCOUNT_EN enables the registered
// window popcount; without it pop_count is tied to 0.
// Ports:
//   clock           in   rising-edge clock
//   resetn          in   synchronous active-low reset
//   restart         in   start a new window (index forced to 0)
//   in_valid        in   transfer block presented
//   bitmask         in   operand non-zero mask (stable per window)
//   mutual_bitmask  in   positions non-zero in both operands
//   out_valid       out  registered in_valid
//   dense_bitmask   out  per-element mutual select
//   window_index    out  start position of the next block
//   window_done     out  this block exhausted the window
//   pop_count       out  popcount(bitmask)
module cl_mask_filter
    import cl_mask_pkg::*;
#(
    parameter int COMPRESSION_WINDOW_SIZE = 8,
    parameter int TRANSFER_SIZE = 2,
    localparam int COUNT_W = countWidth(TRANSFER_SIZE),
    localparam int IDX_W = idxWidth(COMPRESSION_WINDOW_SIZE),
    localparam int POP_W = popWidth(COMPRESSION_WINDOW_SIZE)
)(
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               restart,
    input  logic                               in_valid,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] bitmask,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] mutual_bitmask,
    output logic                               out_valid,
    output logic [TRANSFER_SIZE-1:0]           dense_bitmask,
    output logic [IDX_W-1:0]                   window_index,
    output logic                               window_done,
    output logic [POP_W-1:0]                   pop_count
);

    localparam int W = COMPRESSION_WINDOW_SIZE;
    localparam int T = TRANSFER_SIZE;
    localparam logic [COUNT_W-1:0] SAT = COUNT_W'(T);

    typedef logic [IDX_W:0] idx_ext_t;
    localparam idx_ext_t WIN_END = idx_ext_t'(W);

    logic [IDX_W-1:0]             startIdx;
    logic [W-1:0]                 effMask;
    logic [W-1:0][COUNT_W-1:0]    accIndex;
    logic [T-1:0]                 denseNext;
    idx_ext_t                     nextIdx;
    logic                         moreAbove;
    logic                         doneNext;

    assign startIdx = restart ? '0 : window_index;

    always_comb begin
        effMask = '0;
        for (int i = 0; i < W; i++) begin
            effMask[i] = bitmask[i] && (i >= int'(startIdx));
        end
    end

    cl_mask_accumulator #(
        .COMPRESSION_WINDOW_SIZE(W),
        .TRANSFER_SIZE(T)
    ) u_accumulator (
        .effMask(effMask[W-2:0]),
        .accIndex(accIndex)
    );

    // nextIdx ends up one past the highest in-block position because the
    // scan runs upward; an empty block leaves it at the window end.
    always_comb begin
        denseNext = '0;
        nextIdx   = WIN_END;
        moreAbove = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (effMask[i] && (accIndex[i] < SAT)) begin
                for (int k = 0; k < T; k++) begin
                    if (accIndex[i] == COUNT_W'(k)) begin
                        denseNext[k] = mutual_bitmask[i];
                    end
                end
                nextIdx = idx_ext_t'(i + 1);
            end
        end
        for (int i = 0; i < W; i++) begin
            if (effMask[i] && (i >= int'(nextIdx))) begin
                moreAbove = 1'b1;
            end
        end
        doneNext = !moreAbove || (nextIdx == WIN_END);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            dense_bitmask <= '0;
            window_index  <= '0;
            window_done   <= 1'b0;
        end else begin
            out_valid     <= in_valid;
            dense_bitmask <= in_valid ? denseNext : '0;
            window_done   <= in_valid && doneNext;
            if (in_valid) begin
                window_index <= doneNext ? '0 : nextIdx[IDX_W-1:0];
            end else if (restart) begin
                window_index <= '0;
            end
        end
    end

`ifdef CL_MASK_FILTER_POPCOUNT_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pop_count <= '0;
        end else begin
            pop_count <= POP_W'(satPopcount(MAX_W'(bitmask), W));
        end
    end
`else
    assign pop_count = '0;
`endif

endmodule

// File: tb/tb_cl_mask_filter.sv
module tb_cl_mask_filter;

    localparam int W = 8;
    localparam int T = 2;
`ifdef CL_MASK_FILTER_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           resetn;
    logic           restart;
    logic           in_valid;
    logic [W-1:0]   bitmask;
    logic [W-1:0]   mutual_bitmask;
    logic           out_valid;
    logic [T-1:0]   dense_bitmask;
    logic [2:0]     window_index;
    logic           window_done;
    logic [3:0]     pop_count;

    cl_mask_filter #(
        .COMPRESSION_WINDOW_SIZE(W),
        .TRANSFER_SIZE(T)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .restart(restart),
        .in_valid(in_valid),
        .bitmask(bitmask),
        .mutual_bitmask(mutual_bitmask),
        .out_valid(out_valid),
        .dense_bitmask(dense_bitmask),
        .window_index(window_index),
        .window_done(window_done),
        .pop_count(pop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [T-1:0] dense;
        int           idx;
        bit           done;
        int           pop;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   modelIdx = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: list the set positions from the start index upward, the
    // block is the first T of them.
    function automatic exp_t predict(input logic [W-1:0] bm, input logic [W-1:0] mu, input int s);
        int   pos[$];
        exp_t e;
        for (int i = s; i < W; i++) if (bm[i]) pos.push_back(i);
        e.dense = '0;
        for (int k = 0; k < T && k < pos.size(); k++) e.dense[k] = mu[pos[k]];
        if (pos.size() <= T) begin
            e.done = 1'b1;
            e.idx  = 0;
        end else begin
            e.done = 1'b0;
            e.idx  = pos[T-1] + 1;
        end
        e.pop = POP_EN ? $countones(bm) : 0;
        return e;
    endfunction

    task automatic cycle(input bit v, input bit rs, input logic [W-1:0] bm, input logic [W-1:0] mu);
        exp_t e;
        @(negedge clock);
        resetn = 1'b1;
        in_valid = v;
        restart = rs;
        bitmask = bm;
        mutual_bitmask = mu;
        if (v) begin
            e = predict(bm, mu, rs ? 0 : modelIdx);
            modelIdx = e.idx;
            sb.push_back(e);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        resetn = 1'b0;
        in_valid = 1'b0;
        restart = 1'b0;
        modelIdx = 0;
        @(posedge clock);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_dense", int'(dense_bitmask), 0);
        check("reset_index", int'(window_index), 0);
        check("reset_done", int'(window_done), 0);
        check("reset_pop", int'(pop_count), 0);
    endtask

    task automatic idleCheck();
        cycle(1'b0, 1'b0, bitmask, mutual_bitmask);
        @(posedge clock);
        #1;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_index", int'(window_index), modelIdx);
    endtask

    // Monitor: compares every presented output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("dense", int'(dense_bitmask), int'(e.dense));
                    check("index", int'(window_index), e.idx);
                    check("done", int'(window_done), int'(e.done));
                    check("pop", int'(pop_count), e.pop);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] bm;
        logic [W-1:0] mu;
        bit           v;
        bit           rs;

        resetn = 1'b0;
        restart = 1'b0;
        in_valid = 1'b0;
        bitmask = '0;
        mutual_bitmask = '0;
        repeat (2) @(posedge clock);
        #1;
        check("init_out_valid", int'(out_valid), 0);
        check("init_index", int'(window_index), 0);
        check("init_done", int'(window_done), 0);

        // reference window
        repeat (3) cycle(1'b1, 1'b0, 8'hF6, 8'h66);
        // empty window
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        // full window
        repeat (4) cycle(1'b1, 1'b0, 8'hFF, 8'h00);
        // partial last block
        repeat (2) cycle(1'b1, 1'b0, 8'h07, 8'h07);
        // restart mid-window, then idle keeps the index
        cycle(1'b1, 1'b0, 8'hF6, 8'h66);
        cycle(1'b1, 1'b1, 8'hF6, 8'h66);
        idleCheck();
        // reset mid-window
        cycle(1'b1, 1'b0, 8'hF6, 8'h66);
        doReset();
        // mutual bits outside bitmask are ignored
        cycle(1'b1, 1'b0, 8'h03, 8'h0C);

        bm = 8'hF6;
        mu = 8'h66;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                doReset();
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                rs = v && ($urandom_range(0, 9) == 0);
                if (modelIdx == 0 || rs) begin
                    case ($urandom_range(0, 7))
                        0:       bm = 8'h00;
                        1:       bm = 8'hFF;
                        default: bm = W'($urandom);
                    endcase
                    mu = ($urandom_range(0, 1) == 0) ? (W'($urandom) & bm) : W'($urandom);
                end
                cycle(v, rs, bm, mu);
            end
        end

        repeat (3) cycle(1'b0, 1'b0, bm, mu);
        @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
